// File: rtl/icache.sv
// icache: direct-mapped, read-only instruction cache with one-word lines.
// A fetch is latched in IDLE and looked up in the following cycle. A hit is
// answered during that LOOKUP cycle. A miss issues one word request to the
// memory controller, fills the line and answers from RESP.
//
// Ports
//   clk, rst           clock; asynchronous active-low reset
//   rdy                global ready; low freezes state, array and counters
//   jump_or_not        pipeline redirect; cancels delivery of the current fetch
//   if_addr/if_request fetch address (bits 1:0 ignored) and level request
//   if_inst/if_enable  returned instruction and its one-cycle strobe
//   mc_addr/mc_request word address and miss request to the memory controller
//   mc_inst/mc_enable  returned word and its one-cycle strobe
//   hit_cnt/miss_cnt   lookup statistics (only when ICACHE_STATS_EN is defined)
//
// Build option: define ICACHE_STATS_EN to add the hit/miss counters.
//
// if_enable and if_inst are decoded from registered state and the array
// read. Answering in LOOKUP itself is what gives one-cycle hit latency, and
// it lets a redirect or a low rdy in that cycle withhold the strobe.
module icache #(
  parameter int unsigned INDEX_W = 7,
  parameter int unsigned ADDR_W  = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        jump_or_not,
  input  logic [31:0] if_addr,
  input  logic        if_request,
  output logic [31:0] if_inst,
  output logic        if_enable,
  output logic [31:0] mc_addr,
  output logic        mc_request,
  input  logic [31:0] mc_inst,
  input  logic        mc_enable
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int unsigned LINES = 1 << INDEX_W;
  localparam int unsigned TAG_W = ADDR_W - INDEX_W - 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    MISS   = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Latched fetch: word address only, byte offset dropped.
  logic [31:2] req_addr_q, req_addr_d;
  logic        drop_q, drop_d;
  logic [31:0] inst_q, inst_d;
  logic        mc_request_q, mc_request_d;
  logic [31:0] mc_addr_q, mc_addr_d;
  logic        fill_we;

  // Line storage; only the valid bits need a reset.
  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  logic [INDEX_W-1:0] req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic               req_io;
  logic               lookup_hit;

  // The byte offset is not part of any cache decision.
  logic unused_offset;
  assign unused_offset = ^if_addr[1:0];

  assign req_idx    = req_addr_q[INDEX_W+1:2];
  assign req_tag    = req_addr_q[ADDR_W-1:INDEX_W+2];
  // I/O space is uncacheable: always a miss, never allocated.
  assign req_io     = (req_addr_q[17:16] == 2'b11);
  assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag) && !req_io;

`ifdef ICACHE_STATS_EN
  logic hit_inc, miss_inc;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      req_addr_q   <= '0;
      drop_q       <= 1'b0;
      inst_q       <= '0;
      mc_request_q <= 1'b0;
      mc_addr_q    <= '0;
    end else begin
      state_q      <= state_d;
      req_addr_q   <= req_addr_d;
      drop_q       <= drop_d;
      inst_q       <= inst_d;
      mc_request_q <= mc_request_d;
      mc_addr_q    <= mc_addr_d;
    end
  end

  // Next-state and register updates; nothing moves while rdy is low.
  always_comb begin
    state_d      = state_q;
    req_addr_d   = req_addr_q;
    drop_d       = drop_q;
    inst_d       = inst_q;
    mc_request_d = mc_request_q;
    mc_addr_d    = mc_addr_q;
    fill_we      = 1'b0;
`ifdef ICACHE_STATS_EN
    hit_inc      = 1'b0;
    miss_inc     = 1'b0;
`endif
    if (rdy) begin
      unique case (state_q)
        IDLE: begin
          if (if_request && !jump_or_not) begin
            req_addr_d = if_addr[31:2];
            state_d    = LOOKUP;
          end
        end
        LOOKUP: begin
          if (jump_or_not) begin
            state_d = IDLE;
          end else if (lookup_hit) begin
            state_d = IDLE;
`ifdef ICACHE_STATS_EN
            hit_inc = 1'b1;
`endif
          end else begin
            state_d      = MISS;
            mc_request_d = 1'b1;
            mc_addr_d    = {req_addr_q, 2'b00};
            drop_d       = 1'b0;
`ifdef ICACHE_STATS_EN
            miss_inc     = 1'b1;
`endif
          end
        end
        MISS: begin
          if (mc_enable) begin
            // The fill always completes; a redirect only skips delivery.
            fill_we      = !req_io;
            inst_d       = mc_inst;
            mc_request_d = 1'b0;
            drop_d       = 1'b0;
            state_d      = (drop_q || jump_or_not) ? IDLE : RESP;
          end else if (jump_or_not) begin
            drop_d = 1'b1;
          end
        end
        RESP: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Valid bits: cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (fill_we) begin
      valid_q[req_idx] <= 1'b1;
    end
  end

  // Tag and data write on fill.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_q[req_idx]  <= req_tag;
      data_q[req_idx] <= mc_inst;
    end
  end

`ifdef ICACHE_STATS_EN
  // Lookup statistics; wrap naturally at 32 bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit_inc) begin
        hit_cnt <= hit_cnt + 32'd1;
      end
      if (miss_inc) begin
        miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`endif

  // Response decode: strobe only in an answering state with rdy high and no redirect.
  assign if_enable  = rdy && !jump_or_not &&
                      (((state_q == LOOKUP) && lookup_hit) || (state_q == RESP));
  assign if_inst    = (state_q == LOOKUP) ? data_q[req_idx] : inst_q;
  assign mc_request = mc_request_q;
  assign mc_addr    = mc_addr_q;

endmodule

// File: tb/tb_icache.sv
// Testbench for icache: directed scenarios plus randomized fetches, checked
// by a scoreboard against a behavioural cache model.
module tb_icache;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        jump_or_not;
  logic [31:0] if_addr;
  logic        if_request;
  logic [31:0] if_inst;
  logic        if_enable;
  logic [31:0] mc_addr;
  logic        mc_request;
  logic [31:0] mc_inst;
  logic        mc_enable;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  icache dut (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .jump_or_not (jump_or_not),
    .if_addr     (if_addr),
    .if_request  (if_request),
    .if_inst     (if_inst),
    .if_enable   (if_enable),
    .mc_addr     (mc_addr),
    .mc_request  (mc_request),
    .mc_inst     (mc_inst),
    .mc_enable   (mc_enable)
`ifdef ICACHE_STATS_EN
    ,
    .hit_cnt     (hit_cnt),
    .miss_cnt    (miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] inst;
    logic        hit;
  } exp_t;

  exp_t        exp_q [$];
  logic [31:0] exp_mc [$];
  int          compared;
  int          mismatched;

  // Reference model: 128 one-word lines, tag = addr[17:9], index = addr[8:2].
  logic        m_valid [128];
  logic [8:0]  m_tag   [128];
  logic [31:0] m_data  [128];
  int          m_hits;
  int          m_misses;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0104) return 32'h00A0_0093;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 128; i++) m_valid[i] = 1'b0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic predict(input logic [31:0] a, output exp_t e);
    int         idx;
    logic [8:0] tg;
    logic       io;
    idx = int'(a[8:2]);
    tg  = a[17:9];
    io  = (a[17:16] == 2'b11);
    if (!io && m_valid[idx] && (m_tag[idx] == tg)) begin
      e.inst = m_data[idx];
      e.hit  = 1'b1;
      m_hits++;
    end else begin
      e.inst = mem_word({a[31:2], 2'b00});
      e.hit  = 1'b0;
      m_misses++;
      if (!io) begin
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tg;
        m_data[idx]  = e.inst;
      end
    end
  endtask

  // Normal fetch: expectation goes to the scoreboard, the monitor checks it.
  task automatic fetch(input logic [31:0] a);
    exp_t e;
    int   lat;
    bit   got;
    predict(a, e);
    exp_q.push_back(e);
    if (!e.hit) exp_mc.push_back({a[31:2], 2'b00});
    @(negedge clk);
    if_addr    = a;
    if_request = 1'b1;
    got = 1'b0;
    lat = 0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (if_enable) got = 1'b1;
    end
    if_request = 1'b0;
    if (!got) begin
      compared++;
      mismatched++;
      $display("FAIL fetch_timeout: addr %h got no if_enable, expected one", a);
    end else if (e.hit) begin
      check("hit_latency", 32'(lat), 32'd1);
    end
  endtask

  // Fetch redirected two cycles into its miss: fill completes, no delivery.
  task automatic fetch_drop(input logic [31:0] a);
    exp_t e;
    bit   seen;
    predict(a, e);
    if (!e.hit) exp_mc.push_back({a[31:2], 2'b00});
    @(negedge clk);
    if_addr    = a;
    if_request = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (mc_request) seen = 1'b1;
    end
    check("drop_miss_issued", 32'(seen), 32'd1);
    @(negedge clk);
    jump_or_not = 1'b1;
    if_request  = 1'b0;
    @(negedge clk);
    jump_or_not = 1'b0;
    seen = 1'b1;
    for (int k = 0; k < 30 && seen; k++) begin
      @(negedge clk);
      if (!mc_request) seen = 1'b0;
    end
    check("drop_fill_done", 32'(seen), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  // Memory responder: checks the request address, answers after 2..6 cycles.
  initial begin
    logic [31:0] a0;
    int          d;
    bit          alive;
    mc_enable = 1'b0;
    mc_inst   = '0;
    forever begin
      @(negedge clk);
      if (rst && mc_request) begin
        a0 = mc_addr;
        if (exp_mc.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL mc_unexpected: got request for %h, expected none", a0);
        end else begin
          check("mc_addr", a0, exp_mc.pop_front());
        end
        d     = $urandom_range(2, 6);
        alive = 1'b1;
        for (int k = 0; k < d && alive; k++) begin
          @(negedge clk);
          if (!mc_request) alive = 1'b0;
          else check("mc_addr_stable", mc_addr, a0);
        end
        if (alive) begin
          mc_inst   = mem_word(a0);
          mc_enable = 1'b1;
          @(negedge clk);
          mc_enable = 1'b0;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every if_enable.
  initial begin
    exp_t e;
    bit   saw_mc;
    bit   prev_en;
    saw_mc  = 1'b0;
    prev_en = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (mc_request) saw_mc = 1'b1;
        if (if_enable) begin
          check("enable_gap", 32'(prev_en), 32'd0);
          if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL if_unexpected: got if_enable with inst %h, expected none", if_inst);
          end else begin
            e = exp_q.pop_front();
            check("if_inst", if_inst, e.inst);
            check("hit_vs_miss", 32'(!saw_mc), 32'(e.hit));
          end
          saw_mc = 1'b0;
        end else if (!if_request && !mc_request) begin
          saw_mc = 1'b0;
        end
        prev_en = if_enable;
      end else begin
        saw_mc  = 1'b0;
        prev_en = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t        e;
    bit          seen;
    logic [31:0] a;
`ifdef ICACHE_STATS_EN
    logic [31:0] miss_base;
`endif
    compared    = 0;
    mismatched  = 0;
    rst         = 1'b0;
    rdy         = 1'b1;
    jump_or_not = 1'b0;
    if_addr     = '0;
    if_request  = 1'b0;
    model_reset();

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_if_enable", 32'(if_enable), 32'd0);
    check("rst_if_inst", if_inst, 32'd0);
    check("rst_mc_request", 32'(mc_request), 32'd0);
    check("rst_mc_addr", mc_addr, 32'd0);
`ifdef ICACHE_STATS_EN
    check("rst_hit_cnt", hit_cnt, 32'd0);
    check("rst_miss_cnt", miss_cnt, 32'd0);
`endif
    rst = 1'b1;

    // Cold miss, then hit.
    fetch(32'h0000_0104);
    fetch(32'h0000_0104);

    // Conflict eviction at one index.
`ifdef ICACHE_STATS_EN
    miss_base = miss_cnt;
`endif
    fetch(32'h0000_0004);
    fetch(32'h0000_0204);
    fetch(32'h0000_0004);
`ifdef ICACHE_STATS_EN
    @(negedge clk);
    check("conflict_miss_cnt", miss_cnt - miss_base, 32'd3);
`endif

    // Redirect during a miss still fills the line.
    fetch_drop(32'h0000_0008);
    fetch(32'h0000_0008);

    // I/O bypass leaves the shared index intact.
    fetch(32'h0000_0000);
    fetch(32'h0003_0000);
    fetch(32'h0003_0000);
    fetch(32'h0000_0000);

    // rdy stall during LOOKUP of a hit.
    predict(32'h0000_0104, e);
    exp_q.push_back(e);
    @(negedge clk);
    if_addr    = 32'h0000_0104;
    if_request = 1'b1;
    @(posedge clk);
    #1 rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_if_enable", 32'(if_enable), 32'd0);
      check("stall_mc_request", 32'(mc_request), 32'd0);
    end
    @(posedge clk);
    #1 rdy = 1'b1;
    @(negedge clk);
    check("stall_release_enable", 32'(if_enable), 32'd1);
    if_request = 1'b0;

    // Redirect during LOOKUP suppresses the hit strobe.
    @(negedge clk);
    @(negedge clk);
    if_addr    = 32'h0000_0104;
    if_request = 1'b1;
    @(posedge clk);
    #1;
    jump_or_not = 1'b1;
    if_request  = 1'b0;
    @(negedge clk);
    check("lookup_redirect_enable", 32'(if_enable), 32'd0);
    @(negedge clk);
    jump_or_not = 1'b0;
    fetch(32'h0000_0104);

    // Randomized fetches over a small footprint to mix hits, conflicts and I/O.
    for (int n = 0; n < 250; n++) begin
      a        = '0;
      a[8:2]   = 7'($urandom_range(0, 15));
      a[17:9]  = 9'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a[17:16] = 2'b11;
      a[1:0]   = 2'($urandom);
      fetch(a);
    end

    // Asynchronous reset in the middle of a miss.
    predict(32'h0002_FFF0, e);
    exp_mc.push_back(32'h0002_FFF0);
    @(negedge clk);
    if_addr    = 32'h0002_FFF0;
    if_request = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (mc_request) seen = 1'b1;
    end
    check("rstmiss_request_seen", 32'(seen), 32'd1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("rstmiss_mc_request", 32'(mc_request), 32'd0);
    check("rstmiss_if_enable", 32'(if_enable), 32'd0);
    if_request = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
    fetch(32'h0002_FFF0);

    repeat (5) @(negedge clk);
`ifdef ICACHE_STATS_EN
    check("final_hit_cnt", hit_cnt, 32'(m_hits));
    check("final_miss_cnt", miss_cnt, 32'(m_misses));
`endif
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("mc_queue_drained", 32'(exp_mc.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
